// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: turns load/store requests from the core into
// a stalled request/acknowledge transaction on the external memory bus.
module data_mem_ctrl #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_write,
   input  logic        mem_read,
   input  logic [31:0] alu_res,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        fault,
   output logic [1:0]  fault_code,
   output logic [1:0]  dbg_state
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   read_data_q, read_data_d;
   logic [31:0]   bus_addr_q, bus_addr_d;
   logic [31:0]   bus_wdata_q, bus_wdata_d;
   logic          bus_we_q, bus_we_d;
   logic          fault_q, fault_d;
   logic [1:0]    fault_code_q, fault_code_d;
   logic          stall_c, req_c;
   logic [31:0]   read_data_c;
   logic          access, aligned;

   assign access  = mem_write | mem_read;
   assign aligned = (alu_res[1:0] == 2'b00);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      read_data_d  = read_data_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      bus_we_d     = bus_we_q;
      fault_d      = fault_q;
      fault_code_d = fault_code_q;
      stall_c      = 1'b0;
      req_c        = 1'b0;
      read_data_c  = read_data_q;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (aligned) begin
                  bus_addr_d  = {alu_res[31:2], 2'b00};
                  bus_wdata_d = write_data;
                  bus_we_d    = mem_write;
                  cnt_d       = '0;
                  stall_c     = 1'b1;
                  state_d     = BUSY;
               end else begin
                  // Misaligned accesses never reach the bus; the load result reads as zero.
                  read_data_c = '0;
                  read_data_d = '0;
                  fault_d     = 1'b1;
                  if (fault_code_q == 2'b00) fault_code_d = 2'b01;
               end
            end
         end
         BUSY: begin
            req_c   = 1'b1;
            stall_c = 1'b1;
            if (bus_ack) begin
               if (!bus_we_q) read_data_d = bus_rdata;
               state_d = DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               read_data_d = '0;
               fault_d     = 1'b1;
               if (fault_code_q == 2'b00) fault_code_d = 2'b10;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         read_data_q  <= '0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         bus_we_q     <= 1'b0;
         fault_q      <= 1'b0;
         fault_code_q <= 2'b00;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         read_data_q  <= read_data_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         bus_we_q     <= bus_we_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
      end
   end

   // Gating with reset keeps stall low while reset is held even if requests are present.
   assign stall      = reset & stall_c;
   assign bus_req    = req_c;
   assign read_data  = read_data_c;
   assign bus_addr   = bus_addr_q;
   assign bus_wdata  = bus_wdata_q;
   assign bus_we     = bus_we_q;
   assign fault      = fault_q;
   assign fault_code = fault_code_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a transaction-level model predicts every
// output each cycle, plus literal checks on the headline scenarios.
module tb_data_mem_ctrl;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_write, mem_read;
   logic [31:0] alu_res, write_data;
   logic [31:0] read_data;
   logic        stall, bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        fault;
   logic [1:0]  fault_code;
   logic [1:0]  dbg_state;

   data_mem_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
      .alu_res(alu_res), .write_data(write_data), .read_data(read_data),
      .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .fault(fault), .fault_code(fault_code), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model: latched/sticky values plus per-cycle expectations
   logic [31:0] m_rd, m_addr, m_wdata;
   logic        m_we, m_fault;
   logic [1:0]  m_code;
   logic        e_stall, e_req;
   logic [31:0] e_rdata;
   logic [64:0] exp_q[$];
   logic        chk_en = 1'b0;
   logic        prev_req = 1'b0;
   int          stall_cnt = 0;
   int          req_cnt = 0;

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [64:0] txn;
      if (chk_en) begin
         check("stall", stall, e_stall);
         check("bus_req", bus_req, e_req);
         check("read_data", read_data, e_rdata);
         check("bus_addr", bus_addr, m_addr);
         check("bus_we", bus_we, m_we);
         check("bus_wdata", bus_wdata, m_wdata);
         check("fault", fault, m_fault);
         check("fault_code", fault_code, m_code);
         if (stall) stall_cnt++;
         if (bus_req) req_cnt++;
         if (bus_req && !prev_req) begin
            if (exp_q.size() == 0) begin
               check("bus_issue_unexpected", {bus_we, bus_addr, bus_wdata}, 65'h0);
               if (bus_we == 1'b0 && bus_addr == 32'h0 && bus_wdata == 32'h0) begin
                  errors++;
                  $display("FAIL bus_issue_unexpected actual=issue required=none");
               end
            end else begin
               txn = exp_q.pop_front();
               check("bus_issue", {bus_we, bus_addr, bus_wdata}, txn);
            end
         end
      end
      prev_req = bus_req;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_rd = '0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
      m_fault = 1'b0; m_code = 2'b00;
   endtask

   task automatic idle_cycle(input logic ack);
      mem_read = 1'b0; mem_write = 1'b0;
      bus_ack = ack; bus_rdata = 32'hFFFF_FFFF;
      e_stall = 1'b0; e_req = 1'b0; e_rdata = m_rd;
      step();
      bus_ack = 1'b0;
   endtask

   // One complete load/store; ack arrives after `waits` wait cycles unless give_ack=0.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input int waits,
                            input logic [31:0] rdata, input logic give_ack);
      int busy_n;
      mem_read = rd; mem_write = wr; alu_res = addr; write_data = wd; bus_ack = 1'b0;
      stall_cnt = 0; req_cnt = 0;
      if (addr[1:0] != 2'b00) begin
         e_stall = 1'b0; e_req = 1'b0; e_rdata = '0;
         step();
         m_rd = '0; m_fault = 1'b1;
         if (m_code == 2'b00) m_code = 2'b01;
         mem_read = 1'b0; mem_write = 1'b0;
         return;
      end
      e_stall = 1'b1; e_req = 1'b0; e_rdata = m_rd;
      exp_q.push_back({wr, addr & ~32'h3, wd});
      step();
      m_addr = addr & ~32'h3; m_we = wr; m_wdata = wd;
      mem_read = 1'b0; mem_write = 1'b0;
      busy_n = give_ack ? waits + 1 : TO;
      for (int i = 0; i < busy_n; i++) begin
         e_stall = 1'b1; e_req = 1'b1; e_rdata = m_rd;
         if (give_ack && i == waits) begin
            bus_ack = 1'b1; bus_rdata = rdata;
         end else begin
            bus_ack = 1'b0; bus_rdata = ~rdata;
         end
         step();
      end
      bus_ack = 1'b0;
      if (give_ack) begin
         if (!wr) m_rd = rdata;
      end else begin
         m_rd = '0; m_fault = 1'b1;
         if (m_code == 2'b00) m_code = 2'b10;
      end
      // completion cycle: a stray ack and a new request must both be ignored
      e_stall = 1'b0; e_req = 1'b0; e_rdata = m_rd;
      mem_read = 1'b1; alu_res = 32'h0000_0080; bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
      step();
      mem_read = 1'b0; bus_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b0; mem_write = 1'b0; mem_read = 1'b1; alu_res = '0; write_data = '0;
      bus_ack = 1'b0; bus_rdata = '0;
      model_reset();
      #12;
      check("rst_stall", stall, 1'b0);
      check("rst_bus_req", bus_req, 1'b0);
      check("rst_read_data", read_data, 32'h0);
      check("rst_fault_code", fault_code, 2'b00);
      check("rst_state", dbg_state, 2'd0);
      @(negedge clk);
      reset = 1'b1; mem_read = 1'b0;
      step();
      chk_en = 1'b1;
      idle_cycle(1'b1);

      do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hCAFE_F00D, 1'b1);
      check("load_read_data", read_data, 32'hCAFE_F00D);
      check("load_stall_cycles", stall_cnt, 2);
      check("load_req_cycles", req_cnt, 1);
      check("load_bus_addr", bus_addr, 32'h10);
      check("load_bus_we", bus_we, 1'b0);
      idle_cycle(1'b0);

      do_access(1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678, 5, 32'h0, 1'b1);
      check("store_stall_cycles", stall_cnt, 7);
      check("store_req_cycles", req_cnt, 6);
      check("store_bus_we", bus_we, 1'b1);
      check("store_bus_wdata", bus_wdata, 32'h1234_5678);
      check("store_read_data", read_data, 32'hCAFE_F00D);

      do_access(1'b1, 1'b0, 32'h0000_0103, 32'h0, 0, 32'h0, 1'b1);
      do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2, 32'hA5A5_5A5A, 1'b1);
      do_access(1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 1, 32'h7777_0000, 1'b1);
      check("both_bus_we", bus_we, 1'b1);
      check("both_read_data", read_data, 32'hA5A5_5A5A);
      idle_cycle(1'b1);

      // reset clears the earlier misaligned fault before the timeout scenarios
      @(negedge clk); chk_en = 1'b0; reset = 1'b0;
      model_reset();
      @(negedge clk); reset = 1'b1;
      step(); chk_en = 1'b1;

      do_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, TO - 1, 32'h0BAD_F00D, 1'b1);
      check("ack_at_timeout_fault", fault, 1'b0);
      check("ack_at_timeout_data", read_data, 32'h0BAD_F00D);
      check("ack_at_timeout_req_cycles", req_cnt, TO);

      do_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 0, 32'h0, 1'b0);
      check("timeout_req_cycles", req_cnt, 64);
      check("timeout_read_data", read_data, 32'h0);
      check("timeout_code", fault_code, 2'b10);
      do_access(1'b0, 1'b1, 32'h0000_0301, 32'h99, 0, 32'h0, 1'b1);
      check("timeout_then_misaligned_code", fault_code, 2'b10);
      check("misaligned_no_req", req_cnt, 0);

      @(negedge clk); chk_en = 1'b0; reset = 1'b0;
      model_reset();
      @(negedge clk); reset = 1'b1;
      step(); chk_en = 1'b1;
      do_access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 0, 32'h1111_2222, 1'b1);
      do_access(1'b1, 1'b0, 32'h0000_0006, 32'h0, 0, 32'h0, 1'b1);
      check("misaligned_read_data", read_data, 32'h0);
      check("misaligned_stall", stall_cnt, 0);
      check("misaligned_fault", fault, 1'b1);
      check("misaligned_code", fault_code, 2'b01);
      idle_cycle(1'b0);

      // reset in the third BUSY cycle, then a late ack
      mem_read = 1'b1; alu_res = 32'h0000_0040;
      e_stall = 1'b1; e_req = 1'b0; e_rdata = m_rd;
      exp_q.push_back({1'b0, 32'h0000_0040, write_data});
      step();
      m_addr = 32'h40; m_we = 1'b0; m_wdata = write_data;
      mem_read = 1'b0;
      for (int i = 0; i < 2; i++) begin
         e_stall = 1'b1; e_req = 1'b1; e_rdata = m_rd;
         step();
      end
      #2;
      chk_en = 1'b0; reset = 1'b0;
      #1;
      check("busy_rst_bus_req", bus_req, 1'b0);
      check("busy_rst_stall", stall, 1'b0);
      check("busy_rst_state", dbg_state, 2'd0);
      check("busy_rst_read_data", read_data, 32'h0);
      check("busy_rst_bus_addr", bus_addr, 32'h0);
      model_reset();
      @(negedge clk); reset = 1'b1;
      step(); chk_en = 1'b1;
      idle_cycle(1'b1);
      check("late_ack_state", dbg_state, 2'd0);
      check("late_ack_read_data", read_data, 32'h0);
      idle_cycle(1'b0);

      chk_en = 1'b0;
      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, is the maximum number of BUSY cycles spent waiting for bus_ack before the access is aborted.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 mem_write  in  1  store request from the control unit.
REQ-005 mem_read  in  1  load request from the control unit (the mem_to_reg decode).
REQ-006 alu_res  in  32  byte address from the datapath ALU.
REQ-007 write_data  in  32  store data from the datapath register file.
REQ-008 read_data  out  32  load result to the datapath result mux.
REQ-009 stall  out  1  high: datapath holds pc and suppresses reg_write this cycle.
REQ-010 bus_req  out  1  external memory request, held until acknowledged.
REQ-011 bus_we  out  1  1 = write, 0 = read; valid while bus_req=1.
REQ-012 bus_addr  out  32  word address, {alu_res[31:2],2'b00}, latched.
REQ-013 bus_wdata  out  32  latched write_data.
REQ-014 bus_ack  in  1  memory completion strobe, one cycle wide.
REQ-015 bus_rdata  in  32  read data, valid when bus_ack=1.
REQ-016 fault  out  1  sticky error flag.
REQ-017 fault_code  out  2  00 none, 01 misaligned, 10 timeout; holds the first fault.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-019 An access is defined as access = mem_write | mem_read; when both are high, the access SHALL be treated as a write.
REQ-020 In IDLE, an aligned access (alu_res[1:0]=00) SHALL latch bus_addr, bus_wdata and bus_we, SHALL assert stall combinationally in the same cycle, and SHALL move to BUSY.
REQ-021 In IDLE, a misaligned access SHALL NOT issue bus_req, SHALL keep stall=0, SHALL drive read_data=0, SHALL set fault and set fault_code=01 if it was 00, and SHALL remain in IDLE.
REQ-022 In BUSY, bus_req=1 and stall=1; bus_addr, bus_we and bus_wdata SHALL remain stable.
REQ-023 In BUSY, bus_ack=1 SHALL register bus_rdata into read_data (reads only; writes leave read_data unchanged) and SHALL move to DONE; bus_req SHALL be 0 from the next cycle.
REQ-024 A cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack; when it reaches TIMEOUT, the FSM SHALL move to DONE with read_data=0, fault=1, and fault_code=10 if it was 00.
REQ-025 An ack arriving in the same cycle as the timeout SHALL take priority and SHALL NOT be treated as a fault.
REQ-026 DONE SHALL last exactly one cycle with stall=0 so the instruction retires, SHALL ignore access, and SHALL then return to IDLE.
REQ-027 bus_ack received in IDLE or DONE SHALL be ignored.
REQ-028 Minimum load/store latency SHALL be 3 cycles (IDLE, BUSY with immediate ack, DONE); each extra wait cycle SHALL add one cycle.
REQ-029 With no access in IDLE, stall SHALL be 0 and read_data SHALL hold its value.
REQ-030 fault and fault_code SHALL clear only on reset.

Reset
REQ-031 On reset=0, regardless of state, the block SHALL enter IDLE with bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, read_data=0, fault=0, fault_code=00, and the counter at 0.
REQ-032 Reset during BUSY SHALL drop bus_req asynchronously; a late bus_ack after reset SHALL be ignored.
REQ-033 stall SHALL be 0 while in reset.

Verification
REQ-034 Load from alu_res=0x0000_0010 with ack in the first BUSY cycle and bus_rdata=0xCAFE_F00D -> bus_addr=0x10, bus_we=0, stall high for 2 cycles, read_data=0xCAFE_F00D in DONE.
REQ-035 Store of 0x1234_5678 to 0x0000_0044 with ack after 5 wait cycles -> bus_we=1, bus_wdata stable for 6 cycles, stall high for 7 cycles, read_data unchanged.
REQ-036 Load from 0x0000_0006 -> bus_req never asserts, stall=0, read_data=0, fault=1, fault_code=01.
REQ-037 Load with no ack and TIMEOUT=64 -> bus_req high for exactly 64 cycles, DONE with read_data=0, fault_code=10, and a subsequent misaligned access leaves fault_code=10.
REQ-038 Reset asserted in the 3rd BUSY cycle, then ack pulsed after release -> bus_req=0 immediately, state IDLE, read_data=0, ack ignored.
REQ-039 mem_read=mem_write=1 at 0x20 -> bus_we=1 write issued, read_data unchanged.
